// File: rtl/reference_index_sweep_if.sv
// Index stream channel between the sweep generator and the reference buffer.
// Master drives the valid/index/last, slave returns ready.
interface reference_index_sweep_if #(
    parameter int DATA_W = 4
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/reference_index_sweep.sv
// Emits num_shifts circularly rotated sweeps of reference-buffer read indices; first index 1 cycle after start.
// Holds index/last/shift while tready is low; optional REFERENCE_INDEX_SWEEP_CONTINUOUS_EN repeats runs forever.
module reference_index_sweep #(
    parameter int buffer_length = 10,
    parameter int buffer_bits   = 4,
    parameter int num_shifts    = 4,
    parameter int shift_bits    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    reference_index_sweep_if.master    m_axis_index,
    output logic [shift_bits-1:0]      shift,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [buffer_bits-1:0] LAST_IDX   = buffer_bits'(buffer_length - 1);
    localparam logic [shift_bits-1:0]  LAST_SHIFT = shift_bits'(num_shifts - 1);

    state_t                 r_state;
    logic [buffer_bits-1:0] r_tdata;
    logic [buffer_bits-1:0] r_count;
    logic [shift_bits-1:0]  r_shift;
    logic                   r_done;

    state_t                 w_state_nxt;
    logic [buffer_bits-1:0] w_tdata_nxt;
    logic [buffer_bits-1:0] w_count_nxt;
    logic [shift_bits-1:0]  w_shift_nxt;
    logic                   w_done_nxt;
    logic                   w_run;
    logic                   w_last;
    logic                   w_xfer;
    logic                   w_final_sweep;

    assign w_run         = (r_state == RUN);
    assign w_last        = w_run && (r_count == LAST_IDX);
    assign w_xfer        = w_run && m_axis_index.tready;
    assign w_final_sweep = (r_shift == LAST_SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_tdata_nxt = r_tdata;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_tdata_nxt = '0;
                    w_count_nxt = '0;
                    w_shift_nxt = '0;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_count_nxt = '0;
                        if (!w_final_sweep) begin
                            // next sweep starts rotated by the new shift; shift < buffer_length so no wrap
                            w_shift_nxt = r_shift + shift_bits'(1);
                            w_tdata_nxt = buffer_bits'(r_shift) + buffer_bits'(1);
                        end else begin
                            w_done_nxt = 1'b1;
`ifdef REFERENCE_INDEX_SWEEP_CONTINUOUS_EN
                            w_shift_nxt = '0;
                            w_tdata_nxt = '0;
`else
                            w_state_nxt = DONE;
`endif
                        end
                    end else begin
                        w_count_nxt = r_count + buffer_bits'(1);
                        w_tdata_nxt = (r_tdata == LAST_IDX) ? '0 : r_tdata + buffer_bits'(1);
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tdata <= '0;
            r_count <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tdata <= w_tdata_nxt;
            r_count <= w_count_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign m_axis_index.tvalid = w_run;
    assign m_axis_index.tdata  = r_tdata;
    assign m_axis_index.tlast  = w_last;
    assign shift               = r_shift;
    assign busy                = w_run;
    assign done                = r_done;

endmodule

// File: tb/tb_reference_index_sweep.sv
// Directed bench for reference_index_sweep: default 10x4 instance plus a 5x1 degenerate instance.
// Expected per-cycle outputs come from a table built by a small sweep model.
module tb_reference_index_sweep;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start1;
    logic [1:0] shift;
    logic [0:0] shift1;
    logic       busy, busy1;
    logic       done, done1;

    int n_vec;
    int n_err;

    reference_index_sweep_if #(.DATA_W(4)) ax ();
    reference_index_sweep_if #(.DATA_W(3)) ax1 ();

    reference_index_sweep u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .m_axis_index (ax.master),
        .shift        (shift),
        .busy         (busy),
        .done         (done)
    );

    reference_index_sweep #(
        .buffer_length (5),
        .buffer_bits   (3),
        .num_shifts    (1),
        .shift_bits    (1)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .start        (start1),
        .m_axis_index (ax1.master),
        .shift        (shift1),
        .busy         (busy1),
        .done         (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       rdy;
        logic       vld;
        logic       last;
        logic       busy;
        logic       done;
        logic [3:0] dat;
        logic [1:0] sh;
    } vec_t;

    vec_t vecs[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: transfer k of a run is sweep k/10, position k%10, index rotated by the sweep number.
    task automatic build_run(input int mode);
        int         k;
        logic [7:0] lfsr;
        vec_t       v;
        k    = 0;
        lfsr = 8'hA5 ^ 8'(mode * 37);
        vecs.delete();
        while (k < 40) begin
            lfsr    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            v.rdy   = (mode == 0) ? 1'b1 : lfsr[0];
            v.start = (mode == 2) ? lfsr[1] : 1'b0;
            v.vld   = 1'b1;
            v.dat   = 4'(((k / 10) + (k % 10)) % 10);
            v.last  = ((k % 10) == 9);
            v.sh    = 2'(k / 10);
            v.busy  = 1'b1;
            v.done  = 1'b0;
            vecs.push_back(v);
            if (v.rdy) k++;
        end
`ifdef REFERENCE_INDEX_SWEEP_CONTINUOUS_EN
        v = '{start: (mode == 2), rdy: 1'b1, vld: 1'b1, last: 1'b0, busy: 1'b1,
              done: 1'b1, dat: 4'd0, sh: 2'd0};
        vecs.push_back(v);
        v.done = 1'b0;
        v.dat  = 4'd1;
        vecs.push_back(v);
`else
        v = '{start: (mode == 2), rdy: 1'b1, vld: 1'b0, last: 1'b0, busy: 1'b0,
              done: 1'b1, dat: 4'd0, sh: 2'd3};
        vecs.push_back(v);
        v.start = 1'b0;
        v.done  = 1'b0;
        vecs.push_back(v);
`endif
    endtask

    task automatic apply_vecs(input string tag);
        @(negedge clk);
        ax.tready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (vecs[i]) begin
            cmp($sformatf("%s[%0d].tvalid", tag, i), 32'(ax.tvalid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                cmp($sformatf("%s[%0d].tdata", tag, i), 32'(ax.tdata), 32'(vecs[i].dat));
                cmp($sformatf("%s[%0d].tlast", tag, i), 32'(ax.tlast), 32'(vecs[i].last));
            end
            cmp($sformatf("%s[%0d].shift", tag, i), 32'(shift), 32'(vecs[i].sh));
            cmp($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].busy));
            cmp($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vecs[i].done));
            ax.tready = vecs[i].rdy;
            start     = vecs[i].start;
            @(negedge clk);
        end
        start     = 1'b0;
        ax.tready = 1'b0;
`ifdef REFERENCE_INDEX_SWEEP_CONTINUOUS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        start      = 1'b0;
        start1     = 1'b0;
        ax.tready  = 1'b0;
        ax1.tready = 1'b0;
        #3;
        cmp("rst.tvalid", 32'(ax.tvalid), 32'd0);
        cmp("rst.tdata", 32'(ax.tdata), 32'd0);
        cmp("rst.tlast", 32'(ax.tlast), 32'd0);
        cmp("rst.shift", 32'(shift), 32'd0);
        cmp("rst.busy", 32'(busy), 32'd0);
        cmp("rst.done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        build_run(0);
        apply_vecs("full");
        build_run(1);
        apply_vecs("stall");
        build_run(2);
        apply_vecs("startspam");

        // Reset after 15 transfers: second sweep, index 6, then async clear.
        @(negedge clk);
        start     = 1'b1;
        ax.tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        cmp("mid.tdata", 32'(ax.tdata), 32'd6);
        cmp("mid.shift", 32'(shift), 32'd1);
        cmp("mid.tvalid", 32'(ax.tvalid), 32'd1);
        reset = 1'b1;
        #1;
        cmp("arst.tvalid", 32'(ax.tvalid), 32'd0);
        cmp("arst.tdata", 32'(ax.tdata), 32'd0);
        cmp("arst.tlast", 32'(ax.tlast), 32'd0);
        cmp("arst.shift", 32'(shift), 32'd0);
        cmp("arst.busy", 32'(busy), 32'd0);
        cmp("arst.done", 32'(done), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        ax.tready = 1'b0;
        build_run(0);
        apply_vecs("afterrst");

        // Single-sweep instance of length 5.
        @(negedge clk);
        start1     = 1'b1;
        ax1.tready = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cmp($sformatf("one[%0d].tvalid", j), 32'(ax1.tvalid), 32'd1);
            cmp($sformatf("one[%0d].tdata", j), 32'(ax1.tdata), 32'(j));
            cmp($sformatf("one[%0d].tlast", j), 32'(ax1.tlast), 32'(j == 4));
            cmp($sformatf("one[%0d].shift", j), 32'(shift1), 32'd0);
            @(negedge clk);
        end
        cmp("one.done", 32'(done1), 32'd1);
`ifdef REFERENCE_INDEX_SWEEP_CONTINUOUS_EN
        cmp("one.wrap_tvalid", 32'(ax1.tvalid), 32'd1);
        cmp("one.wrap_tdata", 32'(ax1.tdata), 32'd0);
`else
        cmp("one.end_tvalid", 32'(ax1.tvalid), 32'd0);
        cmp("one.end_busy", 32'(busy1), 32'd0);
`endif
        @(negedge clk);
        cmp("one.done_clear", 32'(done1), 32'd0);
        ax1.tready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reference_index_sweep.md
Name: reference_index_sweep

Overview:
- Address generator directly upstream of the reference sample buffer in the CAF datapath.
- For each lag shift s = 0..num_shifts-1, emits one sweep of buffer_length read indices over an AXI-Stream-style index channel.
- Sweep s starts at index s and wraps modulo buffer_length, so the buffer presents the reference circularly rotated by s.
- Outputs the current shift number and sweep/run boundary markers for the downstream correlator.

Parameters:
- buffer_length, 10, number of samples in the reference buffer; indices 0..buffer_length-1.
- buffer_bits, 4, width of index bus; 2**buffer_bits >= buffer_length.
- num_shifts, 4, number of lag shifts per run; 1 <= num_shifts <= buffer_length.
- shift_bits, 2, width of shift bus; 2**shift_bits >= num_shifts.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle run request; sampled only in IDLE.
- m_axis_index_tready  input  1  downstream ready for an index.
- m_axis_index_tvalid  output  1  index valid.
- m_axis_index_tdata  output  buffer_bits  buffer read index.
- m_axis_index_tlast  output  1  high with the last index of each sweep.
- shift  output  shift_bits  lag shift number of the current sweep.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final index of the final sweep is accepted.

Behaviour:
- Reset (async assert, sync release) values: state=IDLE, tvalid=0, tdata=0, tlast=0, shift=0, busy=0, done=0, internal count=0.
- Transfer occurs on a cycle with tvalid && tready. While tvalid=1 and tready=0, tdata, tlast and shift are held stable.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> RUN next cycle; tvalid=1, tdata=0, shift=0, count=0, busy=1.
  - start=0 -> stay in IDLE, tvalid=0.
- RUN:
  - tvalid stays 1 throughout; no bubbles while tready=1, giving one index per cycle.
  - On each transfer: count<=count+1; tdata<=(tdata==buffer_length-1) ? 0 : tdata+1.
  - tlast=1 exactly when count==buffer_length-1.
  - Transfer with tlast=1 and shift<num_shifts-1: shift<=shift+1, count<=0, tdata<=shift+1. The next sweep follows in the next cycle, with no gap.
  - Transfer with tlast=1 and shift==num_shifts-1: -> DONE; tvalid<=0, busy<=0.
- DONE: done=1 for exactly one cycle -> IDLE. shift keeps its final value until the next start.
- Index arithmetic:
  - Wrap uses compare against buffer_length-1, never a power-of-two mask.
  - tdata never exceeds buffer_length-1.
- Total transfers per run: num_shifts*buffer_length.
- start while in RUN or DONE is ignored; a new run is never queued.
- Degenerate case num_shifts=1: a single sweep 0..buffer_length-1, then DONE.
- Reset mid-run: immediate return to IDLE with all outputs at reset values; a partial sweep is abandoned.
- tready may toggle arbitrarily. Latency from start to first valid index: 1 cycle.

Optional Feature:
- Macro: REFERENCE_INDEX_SWEEP_CONTINUOUS_EN.
- Defined: after the final transfer of the final sweep, done pulses for one cycle while the block stays in RUN. shift wraps to 0 and tdata to 0, and tvalid stays 1 with no gap. Runs repeat until reset; start is ignored after the first run begins.
- Undefined: single-run behaviour as above; the DONE state is used.

Test Plan:
- Defaults, tready=1, start pulse -> tdata sequence 0..9, 1..9,0, 2..9,0,1, 3..9,0,1,2 (40 transfers). tlast on transfers 10/20/30/40; shift 0,1,2,3; done pulse 1 cycle after the 40th; busy low afterwards.
- tready toggled pseudo-randomly during the run -> identical transfer sequence to the tready=1 case. tdata, tlast and shift stable during every stall; no drops or duplicates.
- start asserted repeatedly during RUN and DONE -> no effect. A second start in IDLE -> a fresh run beginning tdata=0, shift=0.
- reset asserted at transfer 15 -> outputs zero asynchronously. After release and a new start, the sequence restarts at 0 with shift=0.
- num_shifts=1, buffer_length=5, buffer_bits=3 -> tdata 0,1,2,3,4, tlast on 4, done follows; 2**buffer_bits=8 range never exceeded.
- With REFERENCE_INDEX_SWEEP_CONTINUOUS_EN defined -> after transfer 40, transfer 41 has tdata=0, shift=0 in the following cycle. done pulses at each run boundary and tvalid never drops.
